// File: rtl/iic_slave_regfile.sv
// I2C write-only slave that feeds a 16 x 9-bit register file.
// Each transaction carries one word: {reg_addr[6:0], data[8]} followed by data[7:0].
module iic_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       Clk_In,
    input  logic       Reset,
    input  logic       IIC_Sclk,
    inout  wire        IIC_Sda,
    input  logic [3:0] Rd_Addr,
    output logic [8:0] Rd_Data,
    output logic       Reg_Wr,
    output logic [6:0] Reg_Addr,
    output logic [8:0] Reg_Data,
    output logic [7:0] Word_Count,
    output logic [9:0] LEDR
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1,
        S_ACK_1, S_BYTE2, S_ACK_2, S_WAIT
    } state_t;

    state_t      state_q;
    logic [2:0]  scl_q, sda_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shift_q, shift_d, b1_q;
    logic        sda_low_q;
    logic        reg_wr_q, bad_q;
    logic [6:0]  reg_addr_q;
    logic [8:0]  reg_data_q;
    logic [7:0]  wc_q;
    logic [8:0]  regs_q [16];

    logic scl_rise, scl_fall, start_c, stop_c, in_byte, byte_done;

    // [1] is the synchronized line, [2] the delayed copy used for edges
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_c   = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_c    = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign in_byte   = (state_q == S_ADDR) || (state_q == S_BYTE1) ||
                       (state_q == S_BYTE2);
    assign byte_done = scl_fall && (cnt_q == 4'd8);
    assign shift_d   = {shift_q[6:0], sda_q[1]};

    // Open-drain: pull low or float, never drive high
    assign IIC_Sda    = sda_low_q ? 1'b0 : 1'bz;
    assign Rd_Data    = regs_q[Rd_Addr];
    assign Reg_Wr     = reg_wr_q;
    assign Reg_Addr   = reg_addr_q;
    assign Reg_Data   = reg_data_q;
    assign Word_Count = wc_q;
    assign LEDR       = {state_q != S_IDLE, bad_q, reg_addr_q[3:0], wc_q[3:0]};

    // Bring the asynchronous bus lines into the Clk_In domain
    always_ff @(posedge Clk_In or negedge Reset) begin
        if (!Reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], IIC_Sclk};
            sda_q <= {sda_q[1:0], IIC_Sda};
        end
    end

    // Protocol FSM: byte shifting, ACK drive and word commit
    always_ff @(posedge Clk_In or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            b1_q       <= '0;
            sda_low_q  <= 1'b0;
            reg_wr_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            wc_q       <= '0;
            bad_q      <= 1'b0;
        end else begin
            reg_wr_q <= 1'b0;
            if (start_c) begin
                state_q   <= S_ADDR;
                cnt_q     <= '0;
                sda_low_q <= 1'b0;
            end else if (stop_c) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                sda_low_q <= 1'b0;
            end else begin
                if (in_byte && scl_rise && cnt_q != 4'd8) begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 4'd1;
                end
                unique case (state_q)
                    S_ADDR: if (byte_done) begin
                        cnt_q <= '0;
                        if (shift_q == {DEV_ADDR, 1'b0}) begin
                            state_q   <= S_ACK_A;
                            sda_low_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_BYTE1: if (byte_done) begin
                        cnt_q     <= '0;
                        b1_q      <= shift_q;
                        state_q   <= S_ACK_1;
                        sda_low_q <= 1'b1;
                    end
                    S_BYTE2: if (byte_done) begin
                        cnt_q      <= '0;
                        state_q    <= S_ACK_2;
                        sda_low_q  <= 1'b1;
                        reg_wr_q   <= 1'b1;
                        reg_addr_q <= b1_q[7:1];
                        reg_data_q <= {b1_q[0], shift_q};
                        wc_q       <= wc_q + 8'd1;
                        if (b1_q[7:5] != 3'b000) bad_q <= 1'b1;
                    end
                    S_ACK_A: if (scl_fall) begin
                        sda_low_q <= 1'b0;
                        state_q   <= S_BYTE1;
                    end
                    S_ACK_1: if (scl_fall) begin
                        sda_low_q <= 1'b0;
                        state_q   <= S_BYTE2;
                    end
                    S_ACK_2: if (scl_fall) begin
                        sda_low_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file update one cycle after the commit pulse; address 15 clears all
    always_ff @(posedge Clk_In or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (reg_wr_q) begin
            if (reg_addr_q == 7'h0F) begin
                for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            end else if (reg_addr_q[6:4] == 3'b000) begin
                regs_q[reg_addr_q[3:0]] <= reg_data_q;
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_regfile.sv
// Bench for iic_slave_regfile: bit-banged I2C master plus a word-level
// model of the register file, counters and flags.
module tb_iic_slave_regfile;

    localparam int Q = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] Rd_Addr = '0;
    wire        sda;
    logic [8:0] Rd_Data;
    logic       Reg_Wr;
    logic [6:0] Reg_Addr;
    logic [8:0] Reg_Data;
    logic [7:0] Word_Count;
    logic [9:0] LEDR;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    iic_slave_regfile dut (
        .Clk_In     (clk),
        .Reset      (rst_n),
        .IIC_Sclk   (scl),
        .IIC_Sda    (sda),
        .Rd_Addr    (Rd_Addr),
        .Rd_Data    (Rd_Data),
        .Reg_Wr     (Reg_Wr),
        .Reg_Addr   (Reg_Addr),
        .Reg_Data   (Reg_Data),
        .Word_Count (Word_Count),
        .LEDR       (LEDR)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    logic chk_en = 1'b0;

    // word-level model
    logic [8:0] m_regs [16];
    logic [7:0] m_wc;
    logic [6:0] m_addr;
    logic [8:0] m_data;
    logic       m_bad;
    int         m_wr = 0;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_wc = '0; m_addr = '0; m_data = '0; m_bad = 1'b0;
    endfunction

    function automatic void m_commit(logic [6:0] a, logic [8:0] d);
        m_wr++;
        m_wc = m_wc + 8'd1;
        m_addr = a;
        m_data = d;
        if (a == 7'h0F) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
        end else if (a < 7'd16) begin
            m_regs[a[3:0]] = d;
        end else begin
            m_bad = 1'b1;
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (Reg_Wr) wr_seen++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("word_count", {24'd0, Word_Count}, {24'd0, m_wc});
            chk("reg_addr", {25'd0, Reg_Addr}, {25'd0, m_addr});
            chk("reg_data", {23'd0, Reg_Data}, {23'd0, m_data});
            chk("rd_data", {23'd0, Rd_Data}, {23'd0, m_regs[Rd_Addr]});
            chk("ledr", {22'd0, LEDR},
                {22'd0, 1'b0, m_bad, m_addr[3:0], m_wc[3:0]});
            chk("wr_pulses", wr_seen, m_wr);
            chk("sda_idle", {31'd0, sda}, 32'd1);
        end
    end

    task automatic wclk(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic idle(int n);
        chk_en = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1 Rd_Addr = 4'($urandom);
        end
        @(posedge clk);
        chk_en = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wclk(Q);
        scl = 1'b1;   wclk(H);
        m_low = 1'b1; wclk(H);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wclk(Q);
        scl = 1'b1;   wclk(H);
        m_low = 1'b0; wclk(H);
    endtask

    task automatic put_bit(logic b);
        m_low = ~b; wclk(Q);
        scl = 1'b1; wclk(H);
        scl = 1'b0; wclk(Q);
    endtask

    task automatic put_byte(logic [7:0] b, logic exp_ack, string name);
        logic ack;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        m_low = 1'b0; wclk(Q);
        scl = 1'b1;   wclk(Q);
        ack = (sda == 1'b0);
        wclk(Q);
        scl = 1'b0;   wclk(Q);
        chk(name, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic wr_word(logic [6:0] a, logic [8:0] d);
        i2c_start();
        put_byte(8'h34, 1'b1, "ack_dev");
        put_byte({a, d[8]}, 1'b1, "ack_b1");
        put_byte(d[7:0], 1'b1, "ack_b2");
        m_commit(a, d);
        i2c_stop();
        idle(6);
    endtask

    task automatic chk_reset_vals();
        chk("rst_word_count", {24'd0, Word_Count}, 32'd0);
        chk("rst_reg_wr", {31'd0, Reg_Wr}, 32'd0);
        chk("rst_reg_addr", {25'd0, Reg_Addr}, 32'd0);
        chk("rst_reg_data", {23'd0, Reg_Data}, 32'd0);
        chk("rst_ledr", {22'd0, LEDR}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            Rd_Addr = 4'(i);
            #1 chk("rst_reg", {23'd0, Rd_Data}, 32'd0);
        end
    endtask

    initial begin
        int wr0;
        logic [6:0] a;
        logic [8:0] d;
        logic [7:0] b;
        m_reset();

        wclk(3);
        chk_reset_vals();
        rst_n = 1'b1;
        wclk(4);

        // single word to register 6
        wr_word(7'h06, 9'h0FF);
        chk("t1_wc", {24'd0, Word_Count}, 32'd1);
        chk("t1_addr", {25'd0, Reg_Addr}, 32'h06);
        chk("t1_data", {23'd0, Reg_Data}, 32'h0FF);
        chk("t1_pulses", wr_seen, 32'd1);
        Rd_Addr = 4'd6;
        #1 chk("t1_rd6", {23'd0, Rd_Data}, 32'h0FF);

        // wrong address and read bit are ignored
        wr0 = wr_seen;
        i2c_start();
        put_byte(8'h36, 1'b0, "nack_36");
        chk("t2_idle", {31'd0, LEDR[9]}, 32'd0);
        i2c_stop();
        i2c_start();
        put_byte(8'h35, 1'b0, "nack_35");
        chk("t2_idle_rd", {31'd0, LEDR[9]}, 32'd0);
        i2c_stop();
        chk("t2_no_wr", wr_seen, wr0);
        idle(4);

        // truncated word is dropped
        i2c_start();
        put_byte(8'h34, 1'b1, "t3_ack_dev");
        chk("t3_busy", {31'd0, LEDR[9]}, 32'd1);
        put_byte(8'h08, 1'b1, "t3_ack_b1");
        i2c_stop();
        idle(4);
        Rd_Addr = 4'd4;
        #1 chk("t3_reg4", {23'd0, Rd_Data}, 32'd0);
        chk("t3_idle", {31'd0, LEDR[9]}, 32'd0);

        // load, then clear via register 15, then an out-of-range address
        for (int i = 0; i < 4; i++)
            wr_word(7'($urandom_range(0, 14)), 9'($urandom_range(1, 511)));
        wr_word(7'h0F, 9'h000);
        for (int i = 0; i < 16; i++) begin
            Rd_Addr = 4'(i);
            #1 chk("t4_cleared", {23'd0, Rd_Data}, 32'd0);
        end
        wr_word(7'h20, 9'h001);
        chk("t4_bad", {31'd0, LEDR[8]}, 32'd1);

        // repeated start inside the data byte restarts the word
        i2c_start();
        put_byte(8'h34, 1'b1, "t5_ack_dev");
        put_byte(8'h0B, 1'b1, "t5_ack_b1");
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        i2c_start();
        put_byte(8'h34, 1'b1, "t5_ack_dev2");
        put_byte(8'h08, 1'b1, "t5_ack_b1b");
        put_byte(8'hF8, 1'b1, "t5_ack_b2");
        m_commit(7'h04, 9'h0F8);
        put_byte(8'hA5, 1'b0, "t5_nack_extra");
        i2c_stop();
        idle(6);
        Rd_Addr = 4'd4;
        #1 chk("t5_reg4", {23'd0, Rd_Data}, 32'h0F8);
        Rd_Addr = 4'd5;
        #1 chk("t5_reg5", {23'd0, Rd_Data}, 32'd0);

        // reset while holding ACK for the first data byte
        i2c_start();
        put_byte(8'h34, 1'b1, "t6_ack_dev");
        for (int i = 7; i >= 0; i--) put_bit(1'b1);
        m_low = 1'b0;
        wclk(1);
        chk("t6_ack_held", {31'd0, sda}, 32'd0);
        #3 rst_n = 1'b0;
        #1 chk("t6_sda_rel", {31'd0, sda}, 32'd1);
        m_reset();
        chk_reset_vals();
        wclk(3);
        rst_n = 1'b1;
        wclk(3);
        wr_word(7'h03, 9'h155);
        chk("t6_wc", {24'd0, Word_Count}, 32'd1);

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 0) begin
                b = 8'($urandom);
                if (b == 8'h34) b = 8'h35;
                i2c_start();
                put_byte(b, 1'b0, "r_nack_dev");
                i2c_stop();
                idle(4);
            end else if (k == 1) begin
                i2c_start();
                put_byte(8'h34, 1'b1, "r_ack_dev");
                put_byte(8'($urandom), 1'b1, "r_ack_b1");
                i2c_stop();
                idle(4);
            end else begin
                k = $urandom_range(0, 9);
                if (k < 6)       a = 7'($urandom_range(0, 14));
                else if (k == 6) a = 7'h0F;
                else if (k == 7) a = 7'($urandom_range(16, 127));
                else             a = 7'($urandom_range(0, 15));
                d = 9'($urandom);
                wr_word(a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_slave_regfile.md
IIC_SLAVE_REGFILE -- requirements
Module: iic_slave_regfile

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit target address (write byte 8'h34).
REQ-002 Clk_In  input  1  system clock, 50 MHz; all state advances on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 IIC_Sclk  input  1  I2C clock from the bus master, asynchronous to Clk_In.
REQ-005 IIC_Sda  inout  1  I2C data, open-drain: the block drives only 1'b0 or 1'bz, never 1'b1.
REQ-006 Rd_Addr  input  4  register file read index.
REQ-007 Rd_Data  output  9  combinational contents of register Rd_Addr.
REQ-008 Reg_Wr  output  1  one-Clk_In-cycle pulse when a register word is committed.
REQ-009 Reg_Addr  output  7  register address of the last accepted word, held until the next word.
REQ-010 Reg_Data  output  9  data of the last accepted word, held until the next word.
REQ-011 Word_Count  output  8  count of accepted words, wraps 8'hFF -> 8'h00.
REQ-012 LEDR  output  10  {busy (state != IDLE), sticky bad-register flag, Reg_Addr[3:0], Word_Count[3:0]}.

Function
REQ-013 IIC_Sclk and IIC_Sda shall pass through 2-flop synchronizers; edge/condition detection uses the synchronized value and a third delayed copy.
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high; bits sampled MSB first on SCL rising edge.
REQ-015 States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
REQ-016 START from any state -> ADDR with bit counter cleared; partial word discarded; repeated START is treated identically.
REQ-017 STOP from any state -> IDLE, SDA released, partial word discarded.
REQ-018 ADDR: after 8 bits, if byte == {DEV_ADDR, 1'b0} -> ACK_A; otherwise (mismatch or R/W=1) -> IDLE with no ACK.
REQ-019 ACK phase: on the SCL falling edge after the 8th bit, drive SDA low; release on the next SCL falling edge and enter the following state.
REQ-020 BYTE1 holds {reg_addr[6:0], data[8]}; BYTE2 holds data[7:0]; both are always ACKed.
REQ-021 On entry to ACK_2 (same Clk_In cycle SDA pull-low begins), Reg_Wr=1 for one cycle, Reg_Addr/Reg_Data update, Word_Count increments.
REQ-022 reg_addr < 16: register[reg_addr] <= data; reg_addr >= 16: no register written, LEDR[8] set (sticky until Reset).
REQ-023 reg_addr == 7'h0F (reset register): all 16 registers cleared to 9'h000; register 15 itself reads 9'h000.
REQ-024 After ACK_2 -> WAIT_STOP; further bytes are not ACKed (SDA released) until START or STOP.
REQ-025 Correct operation requires SCL high and low phases >= 4 Clk_In cycles each; behaviour for faster SCL is undefined.
REQ-026 Rd_Data reflects a write from the cycle after Reg_Wr.

Reset
REQ-027 Reset low shall immediately release IIC_Sda (1'bz) and force state IDLE.
REQ-028 Reset values: registers 9'h000, Reg_Wr 0, Reg_Addr 0, Reg_Data 0, Word_Count 0, LEDR 10'h000, synchronizers 1'b1.
REQ-029 Reset asserted mid-transaction discards the transaction; after release the block waits for a fresh START.

Verification
REQ-030 START, 8'h34, 8'h0C, 8'hFF, STOP -> three ACKs, one Reg_Wr pulse, Reg_Addr=7'h06, Reg_Data=9'h0FF, Rd_Addr=6 gives 9'h0FF, Word_Count=1.
REQ-031 START, 8'h36 -> SDA never driven low on 9th clock, state IDLE, no Reg_Wr; same for 8'h35 (read).
REQ-032 START, 8'h34, 8'h08, STOP -> two ACKs, no Reg_Wr, register 4 unchanged, LEDR[9]=0.
REQ-033 Write 8'h34, 8'h1E, 8'h00 after registers loaded -> all 16 registers read 9'h000; write 8'h34, 8'h40, 8'h01 -> ACKs, no register changes, LEDR[8]=1.
REQ-034 Repeated START inside BYTE2, then 8'h34, 8'h08, 8'hF8 -> only register 4 = 9'h0F8, Word_Count +1; extra fourth byte not ACKed.
REQ-035 Reset asserted while SDA held low in ACK_1 -> SDA 1'bz in same cycle, outputs at reset values, next full write accepted normally.
